// File: rtl/udp_frame_streamer.sv
// udp_frame_streamer
// Streams a double-buffered DRAM frame out over UDP. Each burst of up to
// burst_len words is read from DRAM into a local FIFO, then sent as one packet:
// three fixed header words, a size word, an info word, and the data words.
// When a frame has been fully sent, the active buffer ping-pongs.
// Incoming UDP packets carry run-time commands (rate, burst length, run/pause,
// buffer force).
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   r_enable, r_data    RX word stream (r_enable high for the whole packet)
//   r_ack               RX accept, always 1
//   w_req, w_ack        TX request / grant handshake
//   w_enable, w_data    TX word stream
//   kick                one-cycle DRAM read start
//   busy                DRAM reader busy
//   read_num, read_addr DRAM read length (words) and byte address
//   buf_dout, buf_we    DRAM read data / valid
//   frame_select        active buffer (0 = BASE0, 1 = BASE1)
//   frame_done          one-cycle pulse when the buffer switches
//   overflow            sticky: DRAM data arrived while the FIFO was full
//
// state      | meaning
// -----------+---------------------------------------------------------
// IDLE       | choose between RX, frame switch and a new burst
// RX_HDR     | skip the 4 header words of an RX packet
// RX_CMD     | decode one command per RX word until the packet ends
// REQ        | latch burst size/address, kick DRAM once it is free
// FILL       | wait for the whole burst to land in the FIFO
// UPL_WAIT   | request the TX stream, wait for grant and idle DRAM
// TX_HDR     | send dst IP, src IP, ports, size
// TX_INFO    | send {frame_select, offset}, advance offset
// TX_DATA    | pop the burst out of the FIFO
// SWITCH     | toggle buffer, restart offset, pulse frame_done
module udp_frame_streamer #(
    parameter int          FRAME_WORDS = 1440000,
    parameter int          BURST_MAX   = 64,
    parameter int          FIFO_DEPTH  = 256,
    parameter logic [31:0] BASE0       = 32'h0000_0000,
    parameter logic [31:0] BASE1       = 32'h0100_0000,
    parameter logic [31:0] DST_IP      = 32'h0a00_0003,
    parameter logic [31:0] SRC_IP      = 32'h0a00_0001,
    parameter logic [31:0] PORTS       = 32'h4000_4000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        r_enable,
    input  logic [31:0] r_data,
    output logic        r_ack,
    output logic        w_req,
    input  logic        w_ack,
    output logic        w_enable,
    output logic [31:0] w_data,
    output logic        kick,
    input  logic        busy,
    output logic [31:0] read_num,
    output logic [31:0] read_addr,
    input  logic [31:0] buf_dout,
    input  logic        buf_we,
    output logic        frame_select,
    output logic        frame_done,
    output logic        overflow
);
    localparam int          AW          = $clog2(FIFO_DEPTH);
    localparam logic [31:0] FRAME_W     = 32'(FRAME_WORDS);
    localparam logic [15:0] BURST_MAX_W = 16'(BURST_MAX);
    localparam logic [AW:0] FIFO_FULL_N = (AW+1)'(FIFO_DEPTH);

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_RX_HDR   = 4'd1;
    localparam logic [3:0] S_RX_CMD   = 4'd2;
    localparam logic [3:0] S_REQ      = 4'd3;
    localparam logic [3:0] S_FILL     = 4'd4;
    localparam logic [3:0] S_UPL_WAIT = 4'd5;
    localparam logic [3:0] S_TX_HDR   = 4'd6;
    localparam logic [3:0] S_TX_INFO  = 4'd7;
    localparam logic [3:0] S_TX_DATA  = 4'd8;
    localparam logic [3:0] S_SWITCH   = 4'd9;

    logic [3:0]  state;
    logic [31:0] rd_q;
    logic        rv_q;
    logic [1:0]  hdr_cnt;
    logic [1:0]  tx_hdr_cnt;
    logic [31:0] offset;
    logic [23:0] interval;
    logic [23:0] interval_cnt;
    logic [15:0] burst_len;
    logic        run;
    logic [15:0] n;
    logic [15:0] data_cnt;

    logic [31:0] remaining;
    logic [15:0] n_next;
    logic [15:0] cmd_len;

    logic [31:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   fifo_count;
    logic          fifo_full;
    logic          fifo_push;
    logic          fifo_pop;

    assign r_ack = 1'b1;
    assign w_req = (state == S_UPL_WAIT);

    // ---------------- data FIFO (first-word-fall-through) ----------------
    assign fifo_full = (fifo_count == FIFO_FULL_N);
    assign fifo_push = buf_we && !fifo_full;
    assign fifo_pop  = (state == S_TX_DATA);

    always_ff @(posedge clk) begin
        if (fifo_push) begin
            mem[wr_ptr] <= buf_dout;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (fifo_push) wr_ptr <= wr_ptr + 1'b1;
            if (fifo_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({fifo_push, fifo_pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
            if (buf_we && fifo_full) overflow <= 1'b1;
        end
    end

    // ---------------- burst sizing and command decode ----------------
    always_comb begin
        remaining = FRAME_W - offset;
        if (remaining < {16'd0, burst_len}) n_next = remaining[15:0];
        else                                n_next = burst_len;
    end

    always_comb begin
        cmd_len = rd_q[15:0];
        if (cmd_len == 16'd0)             cmd_len = 16'd1;
        else if (cmd_len > BURST_MAX_W)   cmd_len = BURST_MAX_W;
    end

    // ---------------- main FSM ----------------
    // RX decode runs off the registered word and its registered valid so the
    // last command of a packet is still seen after r_enable drops.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            rd_q         <= '0;
            rv_q         <= 1'b0;
            hdr_cnt      <= '0;
            tx_hdr_cnt   <= '0;
            offset       <= '0;
            interval     <= '0;
            interval_cnt <= '0;
            burst_len    <= BURST_MAX_W;
            run          <= 1'b1;
            n            <= '0;
            data_cnt     <= '0;
            kick         <= 1'b0;
            read_num     <= '0;
            read_addr    <= '0;
            w_enable     <= 1'b0;
            w_data       <= '0;
            frame_select <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            rd_q       <= r_data;
            rv_q       <= r_enable;
            kick       <= 1'b0;
            frame_done <= 1'b0;
            w_enable   <= 1'b0;

            if (state == S_TX_DATA)          interval_cnt <= '0;
            else if (interval_cnt < interval) interval_cnt <= interval_cnt + 1'b1;

            case (state)
                S_IDLE: begin
                    if (r_enable) begin
                        hdr_cnt <= '0;
                        state   <= S_RX_HDR;
                    end else if (offset == FRAME_W) begin
                        state <= S_SWITCH;
                    end else if (run && interval_cnt >= interval) begin
                        state <= S_REQ;
                    end
                end
                S_RX_HDR: begin
                    if (!rv_q)                state <= S_IDLE;
                    else if (hdr_cnt == 2'd3) state <= S_RX_CMD;
                    else                      hdr_cnt <= hdr_cnt + 1'b1;
                end
                S_RX_CMD: begin
                    if (!rv_q) begin
                        state <= S_IDLE;
                    end else begin
                        case (rd_q[31:24])
                            8'h00: interval  <= rd_q[23:0];
                            8'h01: burst_len <= cmd_len;
                            8'h02: run       <= rd_q[0];
                            8'h03: begin
                                frame_select <= rd_q[0];
                                offset       <= '0;
                            end
                            default: ;
                        endcase
                    end
                end
                S_REQ: begin
                    n         <= n_next;
                    read_num  <= {16'd0, n_next};
                    read_addr <= (frame_select ? BASE1 : BASE0) + {offset[29:0], 2'b00};
                    if (!busy) begin
                        kick  <= 1'b1;
                        state <= S_FILL;
                    end
                end
                S_FILL: begin
                    if (32'(fifo_count) >= {16'd0, n}) state <= S_UPL_WAIT;
                end
                S_UPL_WAIT: begin
                    if (w_ack && !busy) begin
                        tx_hdr_cnt <= '0;
                        state      <= S_TX_HDR;
                    end
                end
                S_TX_HDR: begin
                    w_enable <= 1'b1;
                    case (tx_hdr_cnt)
                        2'd0:    w_data <= DST_IP;
                        2'd1:    w_data <= SRC_IP;
                        2'd2:    w_data <= PORTS;
                        default: w_data <= {14'd0, n, 2'b00} + 32'd4;
                    endcase
                    tx_hdr_cnt <= tx_hdr_cnt + 1'b1;
                    if (tx_hdr_cnt == 2'd3) state <= S_TX_INFO;
                end
                S_TX_INFO: begin
                    w_enable <= 1'b1;
                    w_data   <= {frame_select, offset[30:0]};
                    offset   <= offset + {16'd0, n};
                    data_cnt <= n;
                    state    <= S_TX_DATA;
                end
                S_TX_DATA: begin
                    w_enable <= 1'b1;
                    w_data   <= mem[rd_ptr];
                    data_cnt <= data_cnt - 1'b1;
                    if (data_cnt == 16'd1) state <= S_IDLE;
                end
                S_SWITCH: begin
                    frame_select <= ~frame_select;
                    offset       <= '0;
                    frame_done   <= 1'b1;
                    state        <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
